rr_egress_scheduler: RTL

RR_EGRESS_SCHEDULER -- requirements
Module: rr_egress_scheduler

---
 rtl/rr_egress_scheduler_pkg.sv | 20 ++
 rtl/rr_arb3.sv | 32 +++
 rtl/rr_egress_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rr_egress_scheduler_pkg.sv
// Shared definitions for the round-robin egress scheduler: port count,
// header length field position and FSM state encodings.
package rr_egress_scheduler_pkg;

  localparam int NPORTS  = 3;
  // Low bit of the payload-length field; the two bits below it are ignored.
  localparam int LEN_LSB = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_e;

  // High bit of the payload-length field for a given data byte width.
  function automatic int len_msb(input int uwidth);
    return uwidth - 1;
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin selector. Purely combinational: the search for a
// requester starts at the port after the one granted last and wraps around.
module rr_arb3 (
  input  logic [2:0] request_i,
  input  logic [2:0] last_i,
  output logic [2:0] grant_o
);

  // Priority search rotated by the last grant; any non-one-hot last_i
  // falls back to port 1 first.
  always_comb begin
    grant_o = 3'b000;
    case (last_i)
      3'b001: begin
        if      (request_i[1]) grant_o = 3'b010;
        else if (request_i[2]) grant_o = 3'b100;
        else if (request_i[0]) grant_o = 3'b001;
      end
      3'b010: begin
        if      (request_i[2]) grant_o = 3'b100;
        else if (request_i[0]) grant_o = 3'b001;
        else if (request_i[1]) grant_o = 3'b010;
      end
      default: begin
        if      (request_i[0]) grant_o = 3'b001;
        else if (request_i[1]) grant_o = 3'b010;
        else if (request_i[2]) grant_o = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/rr_egress_scheduler.sv
// Packet-atomic round-robin scheduler draining three byte FIFOs onto one
// egress bus. Each packet is a header byte carrying the payload length
// followed by that many payload bytes.
//
// Handshake: rinc[n] is a read strobe towards FIFO n and is only raised
// when rempty[n]=0 and stall_i=0; the FIFO presents the byte on rdatan in
// the following cycle, which is exactly when packet_valid_o is high and
// packet_out carries it. There is no ready on the egress side: stall_i is
// the only backpressure and it simply withholds new strobes.
module rr_egress_scheduler
  import rr_egress_scheduler_pkg::*;
#(
  parameter int UWIDTH = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORTS-1:0] rempty,
  input  logic [UWIDTH-1:0] rdata1,
  input  logic [UWIDTH-1:0] rdata2,
  input  logic [UWIDTH-1:0] rdata3,
  output logic [NPORTS-1:0] rinc,
  input  logic              stall_i,
  input  logic              cnt_clr,
  output logic              packet_valid_o,
  output logic [UWIDTH-1:0] packet_out,
  output logic [NPORTS-1:0] grant_o,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic [CNT_W-1:0]  pkt_cnt2,
  output logic [CNT_W-1:0]  pkt_cnt3,
  output logic [1:0]        debug_state_o
);

  localparam int LEN_MSB = len_msb(UWIDTH);
  localparam int LW      = LEN_MSB - LEN_LSB + 1;

  state_e            state_q, state_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic [NPORTS-1:0] last_q, last_d;
  logic [NPORTS-1:0] rd_q;
  logic [NPORTS-1:0] rinc_d;
  logic [NPORTS-1:0] arb_gnt;
  logic              valid_q;
  logic              grant_evt;
  logic [LW-1:0]     hdr_len;
  logic [CNT_W-1:0]  pkt_cnt1_q, pkt_cnt2_q, pkt_cnt3_q;

  rr_arb3 u_arb (
    .request_i (~rempty),
    .last_i    (last_q),
    .grant_o   (arb_gnt)
  );

  // Egress byte: data of the port strobed last cycle, zero when idle.
  always_comb begin
    packet_out = '0;
    if (valid_q) begin
      case (rd_q)
        3'b001:  packet_out = rdata1;
        3'b010:  packet_out = rdata2;
        3'b100:  packet_out = rdata3;
        default: packet_out = '0;
      endcase
    end
  end

  // In HDR the header byte is the one currently on the egress bus.
  assign hdr_len = packet_out[LEN_MSB:LEN_LSB];

  // Next-state, read strobes, packet length counter and owner tracking.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    rinc_d  = '0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (!stall_i && (arb_gnt != '0)) begin
          rinc_d  = arb_gnt;
          grant_d = arb_gnt;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        cnt_d = hdr_len;
        if (hdr_len != '0) begin
          state_d = ST_PAY;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = grant_q;
        end
      end
      ST_PAY: begin
        if (!stall_i && ((rempty & grant_q) == '0)) begin
          rinc_d = grant_q;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == LW'(1)) begin
            state_d = ST_IDLE;
            grant_d = '0;
            last_d  = grant_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Strobes are forced low while reset is held so no FIFO is touched.
  assign rinc      = rst ? '0 : rinc_d;
  assign grant_evt = (state_q == ST_IDLE) && (rinc_d != '0);

  // FSM, length counter, owner, last grant and one-cycle read pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      last_q  <= 3'b100;
      valid_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      valid_q <= |rinc_d;
      rd_q    <= rinc_d;
    end
  end

  // Saturating per-port packet counters; clear wins over an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt1_q <= '0;
      pkt_cnt2_q <= '0;
      pkt_cnt3_q <= '0;
    end else if (cnt_clr) begin
      pkt_cnt1_q <= '0;
      pkt_cnt2_q <= '0;
      pkt_cnt3_q <= '0;
    end else if (grant_evt) begin
      if (rinc_d[0] && (pkt_cnt1_q != '1)) pkt_cnt1_q <= pkt_cnt1_q + 1'b1;
      if (rinc_d[1] && (pkt_cnt2_q != '1)) pkt_cnt2_q <= pkt_cnt2_q + 1'b1;
      if (rinc_d[2] && (pkt_cnt3_q != '1)) pkt_cnt3_q <= pkt_cnt3_q + 1'b1;
    end
  end

  assign packet_valid_o = valid_q;
  assign grant_o        = grant_q;
  assign pkt_cnt1       = pkt_cnt1_q;
  assign pkt_cnt2       = pkt_cnt2_q;
  assign pkt_cnt3       = pkt_cnt3_q;
  assign debug_state_o  = state_q;

endmodule
